// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the single-port memory.
// Handshake: a requester raises *_req with stable addr/we/wdata and holds it until its one-cycle *_ack.
interface mem_port_if;
  logic        if_req;
  logic [12:0] if_addr;
  logic [7:0]  if_rdata;
  logic        if_ack;

  logic        dm_req;
  logic        dm_we;
  logic [12:0] dm_addr;
  logic [7:0]  dm_wdata;
  logic [7:0]  dm_rdata;
  logic        dm_ack;

  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        busy;
  logic        owner;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data accesses, one transaction at a time,
// with data priority bounded by a starvation counter that eventually forces a fetch grant.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_if.slave  bus,
  output logic [1:0] state_o,
  output logic [3:0] starve_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] WAIT_INIT  = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic        txn_we_q, txn_we_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [12:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  if_rdata_q, if_rdata_d;
  logic [7:0]  dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;

  logic        grant_dm;
  logic        grant_if;

  // Data wins contention unless fetch has already lost STARVE_LIMIT times in a row.
  assign grant_dm = bus.dm_req && !(bus.if_req && (starve_q == STARVE_MAX));
  assign grant_if = bus.if_req && !grant_dm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      txn_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      txn_we_q    <= txn_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    txn_we_d    = txn_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = BUSY;
          wait_d      = WAIT_INIT;
          owner_d     = 1'b1;
          txn_we_d    = bus.dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (bus.if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (grant_if) begin
          state_d     = BUSY;
          wait_d      = WAIT_INIT;
          owner_d     = 1'b0;
          txn_we_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 8'h00;
          starve_d    = '0;
        end
      end
      BUSY: begin
        // The read byte is valid in the last BUSY cycle; the ack follows in DONE.
        if (wait_q == 3'd0) begin
          state_d = DONE;
          if (!txn_we_q) begin
            if (owner_q) begin
              dm_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
          if_ack_d = !owner_q;
          dm_ack_d = owner_q;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

  assign state_o      = state_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: memory models with exact read latency, command and ack scoreboards,
// directed scenarios for fetch, write, contention, mid-transaction reset and a MEM_LAT=4 sweep.
module tb_mem_port_arbiter;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 4;
  localparam int STARVE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_if bus_a ();
  mem_port_if bus_b ();
  logic [1:0] state_a, state_b;
  logic [3:0] starve_a, starve_b;

  mem_port_arbiter #(.MEM_LAT(LAT_A), .STARVE_LIMIT(STARVE)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_o(state_a), .starve_cnt_o(starve_a)
  );
  mem_port_arbiter #(.MEM_LAT(LAT_B), .STARVE_LIMIT(STARVE)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_o(state_b), .starve_cnt_o(starve_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
  endfunction

  // ---------------- memory models ----------------
  logic [7:0]  mem_a [8192];
  logic [7:0]  mem_b [8192];
  logic [7:0]  ref_a [8192];
  logic [12:0] rd_addr_a, rd_addr_b;
  int          rd_age_a, rd_age_b;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem_a[i] <= pat(13'(i));
      mem_b[i] <= pat(13'(i));
      ref_a[i] = pat(13'(i));
    end
    mem_a[5] <= 8'hA7;
    ref_a[5] = 8'hA7;
  end

  always @(posedge clk) begin
    if (rst) begin
      rd_age_a <= 0;
    end else begin
      if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
      if (bus_a.mem_en && !bus_a.mem_we) begin
        rd_addr_a <= bus_a.mem_addr;
        rd_age_a  <= 1;
      end else if (rd_age_a != 0 && rd_age_a < 8) begin
        rd_age_a <= rd_age_a + 1;
      end
    end
  end
  assign bus_a.mem_rdata = (rd_age_a == LAT_A) ? mem_a[rd_addr_a] : 8'hEE;

  always @(posedge clk) begin
    if (rst) begin
      rd_age_b <= 0;
    end else begin
      if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
      if (bus_b.mem_en && !bus_b.mem_we) begin
        rd_addr_b <= bus_b.mem_addr;
        rd_age_b  <= 1;
      end else if (rd_age_b != 0 && rd_age_b < 8) begin
        rd_age_b <= rd_age_b + 1;
      end
    end
  end
  assign bus_b.mem_rdata = (rd_age_b == LAT_B) ? mem_b[rd_addr_b] : 8'hEE;

  // ---------------- scoreboards (DUT A) ----------------
  logic [21:0] mem_exp_q[$];   // {we, addr, wdata-if-write}
  logic [8:0]  ack_exp_q[$];   // {owner, rdata}
  logic [7:0]  last_dm_a = 8'h00;
  int          b_en_cnt  = 0;

  always @(negedge clk) begin
    logic [21:0] me;
    logic [8:0]  ae;
    check_eq("mem_we_with_en", 64'(bus_a.mem_we & ~bus_a.mem_en), 64'(0));
    if (bus_a.mem_en) begin
      check_eq("mem_en_expected", 64'(mem_exp_q.size() != 0), 64'(1));
      if (mem_exp_q.size() != 0) begin
        me = mem_exp_q.pop_front();
        check_eq("mem_cmd", 64'({bus_a.mem_we, bus_a.mem_addr, bus_a.mem_we ? bus_a.mem_wdata : 8'h00}), 64'(me));
      end
    end
    if (bus_a.if_ack || bus_a.dm_ack) begin
      check_eq("ack_expected", 64'(ack_exp_q.size() != 0), 64'(1));
      check_eq("ack_not_both", 64'(bus_a.if_ack & bus_a.dm_ack), 64'(0));
      if (ack_exp_q.size() != 0) begin
        ae = ack_exp_q.pop_front();
        check_eq("ack_owner", 64'({bus_a.dm_ack, bus_a.owner}), 64'({ae[8], ae[8]}));
        check_eq("ack_rdata", 64'(bus_a.dm_ack ? bus_a.dm_rdata : bus_a.if_rdata), 64'(ae[7:0]));
      end
    end
    if (bus_b.mem_en) b_en_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack_a(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus_a.if_ack || bus_a.dm_ack) && n < 40);
    check_eq(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic solo_a(input logic is_dm, input logic we, input logic [12:0] addr, input logic [7:0] wdata);
    logic [7:0] rexp;
    if (is_dm && we) begin
      ref_a[addr] = wdata;
      rexp = last_dm_a;
    end else begin
      rexp = ref_a[addr];
    end
    if (is_dm && !we) last_dm_a = rexp;
    mem_exp_q.push_back({is_dm & we, addr, (is_dm & we) ? wdata : 8'h00});
    ack_exp_q.push_back({is_dm, rexp});
    if (is_dm) begin
      bus_a.dm_req = 1'b1; bus_a.dm_we = we; bus_a.dm_addr = addr; bus_a.dm_wdata = wdata;
    end else begin
      bus_a.if_req = 1'b1; bus_a.if_addr = addr;
    end
    wait_ack_a("solo_latency", LAT_A + 2);
    bus_a.dm_req = 1'b0;
    bus_a.if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    bus_a.if_req = 1'b1; bus_a.if_addr = 13'h0005;
    bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0;
    bus_b.dm_req = 1'b0; bus_b.dm_we = 1'b0; bus_b.dm_addr = '0; bus_b.dm_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state with a fetch request already pending: nothing may be granted yet.
    check_eq("rst_ctrl", 64'({bus_a.busy, bus_a.owner, bus_a.mem_en, bus_a.mem_we,
                              bus_a.if_ack, bus_a.dm_ack, state_a, starve_a}), 64'(0));
    check_eq("rst_data", 64'({bus_a.mem_addr, bus_a.mem_wdata, bus_a.if_rdata, bus_a.dm_rdata}), 64'(0));
    check_eq("rst_busy_b", 64'(bus_b.busy), 64'(0));

    // Single fetch, MEM_LAT=1.
    mem_exp_q.push_back({1'b0, 13'h0005, 8'h00});
    ack_exp_q.push_back({1'b0, 8'hA7});
    rst = 1'b0;
    @(negedge clk);
    check_eq("t1_cycle1", 64'({bus_a.mem_en, bus_a.busy, bus_a.owner, bus_a.mem_addr}), 64'({3'b110, 13'h0005}));
    @(negedge clk);
    check_eq("t1_cycle2", 64'({bus_a.mem_en, bus_a.if_ack}), 64'(0));
    @(negedge clk);
    check_eq("t1_cycle3_ack", 64'({bus_a.if_ack, bus_a.if_rdata}), 64'({1'b1, 8'hA7}));
    bus_a.if_req = 1'b0;
    @(negedge clk);
    check_eq("t1_after", 64'({bus_a.if_ack, bus_a.busy, bus_a.if_rdata}), 64'({2'b00, 8'hA7}));

    // Data write at the top address, then read it back on both ports.
    solo_a(1'b1, 1'b1, 13'h1FFF, 8'h3C);
    check_eq("t2_dm_rdata_kept", 64'(bus_a.dm_rdata), 64'(8'h00));
    solo_a(1'b1, 1'b0, 13'h1FFF, 8'h00);
    solo_a(1'b0, 1'b0, 13'h1FFF, 8'h00);
    solo_a(1'b1, 1'b1, 13'h0000, 8'h5A);
    solo_a(1'b1, 1'b0, 13'h0000, 8'h00);

    for (int k = 0; k < 10; k++) begin
      logic is_dm, we;
      is_dm = 1'($urandom_range(0, 1));
      we    = is_dm & 1'($urandom_range(0, 1));
      solo_a(is_dm, we, 13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)));
    end

    // Contention: both held, expect data x3, fetch, data.
    check_eq("starve_pre", 64'(starve_a), 64'(0));
    bus_a.if_addr = 13'h0100; bus_a.dm_addr = 13'h0200; bus_a.dm_we = 1'b0; bus_a.dm_wdata = 8'h00;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        mem_exp_q.push_back({1'b0, 13'h0100, 8'h00});
        ack_exp_q.push_back({1'b0, ref_a[13'h0100]});
      end else begin
        mem_exp_q.push_back({1'b0, 13'h0200, 8'h00});
        ack_exp_q.push_back({1'b1, ref_a[13'h0200]});
        last_dm_a = ref_a[13'h0200];
      end
    end
    bus_a.if_req = 1'b1;
    bus_a.dm_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack_a("cont_latency", (k == 0) ? LAT_A + 2 : LAT_A + 3);
      check_eq("cont_starve", 64'(starve_a), 64'((k < 3) ? k + 1 : (k == 3) ? 0 : 1));
    end
    bus_a.if_req = 1'b0;
    bus_a.dm_req = 1'b0;
    @(negedge clk);

    // Reset in the second BUSY cycle of a data read: aborted, no ack.
    mem_exp_q.push_back({1'b0, 13'h0033, 8'h00});
    bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b0; bus_a.dm_addr = 13'h0033;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_in_busy", 64'(bus_a.busy), 64'(1));
    rst = 1'b1;
    bus_a.dm_req = 1'b0;
    @(negedge clk);
    check_eq("t4_rst_ctrl", 64'({bus_a.busy, bus_a.owner, bus_a.mem_en, bus_a.mem_we,
                                 bus_a.if_ack, bus_a.dm_ack, state_a, starve_a}), 64'(0));
    check_eq("t4_rst_data", 64'({bus_a.mem_addr, bus_a.mem_wdata, bus_a.if_rdata, bus_a.dm_rdata}), 64'(0));
    rst = 1'b0;
    last_dm_a = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check_eq("t4_idle", 64'({bus_a.busy, bus_a.dm_ack, state_a}), 64'(0));
    end
    solo_a(1'b0, 1'b0, 13'h0000, 8'h00);
    solo_a(1'b1, 1'b1, 13'h0040, 8'hC3);

    // MEM_LAT=4 data read; inputs wiggle during BUSY and must be ignored.
    bus_b.dm_req = 1'b1; bus_b.dm_we = 1'b0; bus_b.dm_addr = 13'h0ABC;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        bus_b.dm_addr = 13'h0123; bus_b.dm_we = 1'b1; bus_b.dm_wdata = 8'hFF;
        bus_b.if_req = 1'b1; bus_b.if_addr = 13'h1FFF;
      end
      if (bus_b.busy && !bus_b.dm_ack) check_eq("b_addr_hold", 64'(bus_b.mem_addr), 64'(13'h0ABC));
    end while (!bus_b.dm_ack && n < 40);
    check_eq("b_latency", 64'(n), 64'(LAT_B + 2));
    check_eq("b_rdata", 64'({bus_b.owner, bus_b.dm_rdata}), 64'({1'b1, pat(13'h0ABC)}));
    bus_b.dm_req = 1'b0;
    bus_b.if_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("b_idle_after", 64'({bus_b.busy, state_b}), 64'(0));
    check_eq("b_one_access", 64'(b_en_cnt), 64'(1));
    check_eq("b_no_write", 64'(mem_b[13'h0123]), 64'(pat(13'h0123)));

    check_eq("mem_q_drained", 64'(mem_exp_q.size()), 64'(0));
    check_eq("ack_q_drained", 64'(ack_exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1: memory read latency in cycles from the mem_en cycle to mem_rdata valid, legal range 1-7.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3: number of consecutive lost arbitrations after which fetch wins, legal range 1-15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch request; held until if_ack.
REQ-006 if_addr  input  13  fetch address; stable while if_req is high.
REQ-007 if_rdata  output  8  fetched byte; valid in the if_ack cycle and held until the next fetch ack.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 dm_req  input  1  data-memory request; held until dm_ack.
REQ-010 dm_we  input  1  1 = write, 0 = read; stable while dm_req is high.
REQ-011 dm_addr  input  13  data address; stable while dm_req is high.
REQ-012 dm_wdata  input  8  write data; stable while dm_req is high.
REQ-013 dm_rdata  output  8  read byte; valid in the dm_ack cycle and held until the next data-read ack.
REQ-014 dm_ack  output  1  one-cycle data completion pulse, for reads and writes.
REQ-015 mem_en  output  1  one-cycle memory access strobe.
REQ-016 mem_we  output  1  write strobe; only ever high together with mem_en.
REQ-017 mem_addr, mem_wdata  output  13, 8  latched address and write data; stable for the whole transaction.
REQ-018 mem_rdata  input  8  memory read data.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 owner  output  1  owner of the current transaction: 0 = fetch, 1 = data.

Function
REQ-021 The block SHALL implement the states IDLE, BUSY and DONE, with exactly one transaction in flight at a time.
REQ-022 IDLE: if no request is pending, the block SHALL remain in IDLE.
REQ-023 IDLE: if exactly one request is pending, the block SHALL grant that requester.
REQ-024 IDLE: if both requests are pending, the block SHALL grant data unless the starvation counter equals STARVE_LIMIT, in which case it SHALL grant fetch.
REQ-025 On a grant, the block SHALL latch the requester's address, we and wdata into the mem_* registers, set owner, load the wait counter with MEM_LAT, and enter BUSY.
REQ-026 Fetch grants SHALL force mem_we to 0.
REQ-027 BUSY SHALL last exactly MEM_LAT+1 cycles, with mem_en high (and mem_we for writes) only in the first BUSY cycle.
REQ-028 In the last BUSY cycle, the block SHALL capture mem_rdata into if_rdata or dm_rdata according to owner, for reads only; writes SHALL leave dm_rdata unchanged. The block then enters DONE.
REQ-029 DONE SHALL last one cycle, assert if_ack or dm_ack according to owner, and then return to IDLE.
REQ-030 The block SHALL ignore requests while in BUSY or DONE.
REQ-031 The requester SHALL deassert req in the cycle after its ack unless it is issuing a new request.
REQ-032 Latency from a request sampled in IDLE to its ack SHALL be MEM_LAT+2 cycles; back-to-back throughput is one transaction per MEM_LAT+3 cycles.
REQ-033 The starvation counter (4 bits) SHALL increment, saturating at STARVE_LIMIT, on each IDLE grant to data while if_req is high.
REQ-034 The starvation counter SHALL clear on every fetch grant and SHALL otherwise hold.
REQ-035 A request dropped before its ack is a protocol violation; the in-flight transaction SHALL still complete and ack.
REQ-036 Address arithmetic SHALL be none; the full 13-bit address SHALL be passed through unmodified, including 0x1FFF.

Reset
REQ-037 While rst is high at a clock edge, the block SHALL enter IDLE and zero the starvation counter, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ack, dm_ack, busy and owner.
REQ-038 A reset during BUSY or DONE SHALL abort the transaction with no ack issued.
REQ-039 The first grant after reset SHALL occur no earlier than the first edge after rst falls.

Verification
REQ-040 Reset then single fetch: MEM_LAT=1, if_req=1, if_addr=0x0005, mem_rdata=0xA7 in cycle 2 -> mem_en only in cycle 1 with mem_addr=0x0005; if_ack and if_rdata=0xA7 in cycle 3.
REQ-041 Data write: dm_we=1, dm_addr=0x1FFF, dm_wdata=0x3C -> mem_en=mem_we=1 for one cycle with mem_addr=0x1FFF, mem_wdata=0x3C; dm_ack after 3 cycles; dm_rdata unchanged.
REQ-042 Contention/starvation: STARVE_LIMIT=3, if_req and dm_req both held high -> grant order is data, data, data, fetch, data...; the counter reads 0 after the fetch grant.
REQ-043 Reset mid-transaction: rst pulsed in the second BUSY cycle -> no ack; all outputs 0 the next cycle; state is IDLE.
REQ-044 Latency sweep: MEM_LAT=4, data read -> ack exactly 6 cycles after the request was sampled in IDLE; requests changing during BUSY are ignored.
